// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
// Holds the FSM state encoding, bus tag fields and line geometry.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic       TAG_OP_READ     = 1'b1;
  localparam logic       TAG_OP_WRITE    = 1'b0;
  localparam logic [3:0] TAG_TYPE_MEMORY = 4'b0001;

  localparam int LINE_BEATS = 8;
  localparam int BEAT_BITS  = $clog2(LINE_BEATS);
  localparam int NUM_PORTS  = 2;

  // Bus tag layout: {op, type, id}.
  function automatic logic [12:0] make_tag(input logic is_read, input logic [7:0] id);
    return {(is_read ? TAG_OP_READ : TAG_OP_WRITE), TAG_TYPE_MEMORY, id};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Sysbus top-side request/response channel between the arbiter and memory.
// The arbiter drives the request side and acknowledges responses.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);

  logic [DATA_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  reqcyc;
  logic                  reqack;
  logic [DATA_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  resptag;
  logic                  respcyc;
  logic                  respack;

  modport master (
    output req, reqtag, reqcyc, respack,
    input  reqack, resp, resptag, respcyc
  );

  modport slave (
    input  req, reqtag, reqcyc, respack,
    output reqack, resp, resptag, respcyc
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter moving 64-byte lines between two clients (instruction,
// data) and the system bus, one transaction outstanding at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_arbiter_if.master        bus,

  input  logic                 c0_req,
  input  logic                 c0_we,
  input  logic [63:0]          c0_addr,
  input  logic [511:0]         c0_wline,
  output logic                 c0_done,
  output logic [511:0]         c0_rline,

  input  logic                 c1_req,
  input  logic                 c1_we,
  input  logic [63:0]          c1_addr,
  input  logic [511:0]         c1_wline,
  output logic                 c1_done,
  output logic [511:0]         c1_rline
);

  localparam int                 LINE_BITS = LINE_BEATS * DATA_WIDTH;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

  state_t                 state_reg, state_next;
  logic [BEAT_BITS-1:0]   beat_reg, beat_next;
  logic                   gnt_reg;
  logic                   last_reg;
  logic                   we_reg;
  logic [57:0]            line_addr_reg;
  logic [LINE_BITS-1:0]   wline_reg;
  logic [LINE_BITS-1:0]   rbuf_reg;

  logic [NUM_PORTS-1:0]   creq;
  logic [NUM_PORTS-1:0]   cwe;
  logic [63:0]            caddr  [NUM_PORTS];
  logic [LINE_BITS-1:0]   cwline [NUM_PORTS];
  logic [NUM_PORTS-1:0]   done_vec;

  logic                   pick;
  logic                   grant_en;
  logic                   resp_hit;
  logic                   commit;
  logic [LINE_BITS-1:0]   line_cap;
  logic [TAG_WIDTH-1:0]   tag_val;
  logic                   unused_bits;

  assign creq      = {c1_req, c0_req};
  assign cwe       = {c1_we, c0_we};
  assign caddr[0]  = c0_addr;
  assign caddr[1]  = c1_addr;
  assign cwline[0] = c0_wline;
  assign cwline[1] = c1_wline;

  assign unused_bits = ^{c0_addr[5:0], c1_addr[5:0], bus.resptag[TAG_WIDTH-1:8]};

  // On a conflict the port that lost last time wins; a lone requester always wins.
  always_comb begin
    pick = 1'b0;
    if (creq[0] && creq[1]) begin
      pick = ~last_reg;
    end else if (creq[1]) begin
      pick = 1'b1;
    end
  end

  assign grant_en = (state_reg == IDLE) && (|creq);
  assign tag_val  = TAG_WIDTH'(make_tag(~we_reg, {7'd0, gnt_reg}));
  assign resp_hit = (state_reg == RESP) && bus.respcyc &&
                    (bus.resptag[7:0] == {7'd0, gnt_reg});
  assign commit   = resp_hit && (beat_reg == LAST_BEAT);

  always_comb begin
    line_cap = rbuf_reg;
    line_cap[beat_reg*DATA_WIDTH +: DATA_WIDTH] = bus.resp;
  end

  always_comb begin
    state_next  = state_reg;
    beat_next   = beat_reg;
    bus.req     = '0;
    bus.reqtag  = '0;
    bus.reqcyc  = 1'b0;
    bus.respack = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|creq) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        bus.reqcyc = 1'b1;
        bus.req    = DATA_WIDTH'({line_addr_reg, 6'b000000});
        bus.reqtag = tag_val;
        if (bus.reqack) begin
          state_next = we_reg ? WDATA : RESP;
        end
      end
      WDATA: begin
        bus.reqcyc = 1'b1;
        bus.req    = wline_reg[beat_reg*DATA_WIDTH +: DATA_WIDTH];
        bus.reqtag = tag_val;
        if (bus.reqack) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end
      RESP: begin
        // Every response beat is acked; only our own tag advances the line.
        bus.respack = bus.respcyc;
        if (resp_hit) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      gnt_reg       <= 1'b0;
      last_reg      <= 1'b1;
      we_reg        <= 1'b0;
      line_addr_reg <= '0;
      wline_reg     <= '0;
      rbuf_reg      <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (grant_en) begin
        gnt_reg       <= pick;
        last_reg      <= pick;
        we_reg        <= cwe[pick];
        line_addr_reg <= caddr[pick][63:6];
        wline_reg     <= cwline[pick];
      end
      if (resp_hit) begin
        rbuf_reg <= line_cap;
      end
    end
  end

  // Each port keeps its last completed read line until its next read finishes.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [LINE_BITS-1:0] rline_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rline_reg <= '0;
      end else if (commit && (gnt_reg == 1'(gi))) begin
        rline_reg <= line_cap;
      end
    end

    assign done_vec[gi] = (state_reg == DONE) && (gnt_reg == 1'(gi));
  end

  assign c0_done  = done_vec[0];
  assign c1_done  = done_vec[1];
  assign c0_rline = g_port[0].rline_reg;
  assign c1_rline = g_port[1].rline_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reads, writes, arbitration,
// ADDR stalls, foreign-tag responses and reset during a transaction.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

  logic         c0_req, c0_we, c0_done;
  logic [63:0]  c0_addr;
  logic [511:0] c0_wline, c0_rline;
  logic         c1_req, c1_we, c1_done;
  logic [63:0]  c1_addr;
  logic [511:0] c1_wline, c1_rline;

  mem_arbiter #(.DATA_WIDTH(64), .TAG_WIDTH(13)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .c0_req   (c0_req),
    .c0_we    (c0_we),
    .c0_addr  (c0_addr),
    .c0_wline (c0_wline),
    .c0_done  (c0_done),
    .c0_rline (c0_rline),
    .c1_req   (c1_req),
    .c1_we    (c1_we),
    .c1_addr  (c1_addr),
    .c1_wline (c1_wline),
    .c1_done  (c1_done),
    .c1_rline (c1_rline)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int p);
    return (p == 0) ? c0_done : c1_done;
  endfunction

  function automatic logic [511:0] rline_of(input int p);
    return (p == 0) ? c0_rline : c1_rline;
  endfunction

  task automatic set_client(input int p, input logic rq, input logic we,
                            input logic [63:0] a, input logic [511:0] wl);
    if (p == 0) begin
      c0_req = rq; c0_we = we; c0_addr = a; c0_wline = wl;
    end else begin
      c1_req = rq; c1_we = we; c1_addr = a; c1_wline = wl;
    end
  endtask

  task automatic clear_req(input int p);
    if (p == 0) c0_req = 1'b0;
    else        c1_req = 1'b0;
  endtask

  // Read one line; the bus returns beat i = base + i. Optional ADDR stall
  // and an optional foreign-tag beat injected before beat 4.
  task automatic do_read(input int p, input logic [63:0] a, input logic [7:0] base,
                         input int stall, input bit inject);
    logic [511:0] exp_line;
    logic [12:0]  tag;
    tag = 13'h1100 | 13'(p);
    for (int i = 0; i < 8; i++) exp_line[64*i +: 64] = 64'(base) + 64'(i);
    set_client(p, 1'b1, 1'b0, a, '0);
    bus.reqack  = 1'b0;
    bus.respcyc = 1'b0;
    tick();
    check("rd_addr_reqcyc", bus.reqcyc, 1);
    check("rd_addr_req", bus.req, {a[63:6], 6'b0});
    check("rd_addr_tag", bus.reqtag, tag);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_reqcyc", bus.reqcyc, 1);
      check("stall_req", bus.req, {a[63:6], 6'b0});
      check("stall_tag", bus.reqtag, tag);
    end
    bus.reqack = 1'b1;
    tick();
    bus.reqack = 1'b0;
    check("rd_resp_reqcyc", bus.reqcyc, 0);
    for (int i = 0; i < 8; i++) begin
      if (inject && i == 4) begin
        bus.respcyc = 1'b1;
        bus.resp    = 64'hdead_beef_0bad_f00d;
        bus.resptag = 13'h1105;
        #1;
        check("foreign_ack", bus.respack, 1);
        tick();
        check("foreign_nodone", done_of(p), 0);
      end
      bus.respcyc = 1'b1;
      bus.resp    = 64'(base) + 64'(i);
      bus.resptag = tag;
      #1;
      check("rd_respack", bus.respack, 1);
      tick();
      if (i < 7) check("rd_early_done", done_of(p), 0);
    end
    bus.respcyc = 1'b0;
    #1;
    check("rd_done", done_of(p), 1);
    check("rd_other_done", done_of(1 - p), 0);
    check("rd_line", rline_of(p), exp_line);
    check("rd_done_reqcyc", bus.reqcyc, 0);
    $display("[TB] read  port %0d addr %0h line beat0 %0h", p, a, rline_of(p)[63:0]);
    clear_req(p);
    tick();
    check("rd_done_pulse", done_of(p), 0);
    check("rd_line_hold", rline_of(p), exp_line);
  endtask

  task automatic do_write(input int p, input logic [63:0] a, input logic [511:0] wl);
    logic [12:0] tag;
    tag = 13'h0100 | 13'(p);
    set_client(p, 1'b1, 1'b1, a, wl);
    bus.reqack  = 1'b1;
    bus.respcyc = 1'b1;
    bus.resptag = 13'h1100 | 13'(p);
    bus.resp    = '0;
    tick();
    check("wr_addr_reqcyc", bus.reqcyc, 1);
    check("wr_addr_req", bus.req, {a[63:6], 6'b0});
    check("wr_addr_tag", bus.reqtag, tag);
    check("wr_respack", bus.respack, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("wr_beat_reqcyc", bus.reqcyc, 1);
      check("wr_beat", bus.req, wl[64*k +: 64]);
      check("wr_beat_respack", bus.respack, 0);
      check("wr_early_done", done_of(p), 0);
    end
    tick();
    check("wr_done", done_of(p), 1);
    check("wr_done_reqcyc", bus.reqcyc, 0);
    check("wr_done_respack", bus.respack, 0);
    $display("[TB] write port %0d addr %0h beat7 %0h", p, a, wl[511:448]);
    bus.reqack  = 1'b0;
    bus.respcyc = 1'b0;
    clear_req(p);
    tick();
    check("wr_done_pulse", done_of(p), 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    #1 reset = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] wl;
    logic [511:0] line_a;
    reset = 1'b0;
    set_client(0, 1'b0, 1'b0, '0, '0);
    set_client(1, 1'b0, 1'b0, '0, '0);
    bus.reqack  = 1'b0;
    bus.resp    = 64'h1234;
    bus.resptag = 13'h1100;
    bus.respcyc = 1'b1;
    repeat (3) tick();
    check("rst_reqcyc", bus.reqcyc, 0);
    check("rst_req", bus.req, 0);
    check("rst_reqtag", bus.reqtag, 0);
    check("rst_respack", bus.respack, 0);
    check("rst_c0_done", c0_done, 0);
    check("rst_c1_done", c1_done, 0);
    check("rst_c0_rline", c0_rline, 0);
    check("rst_c1_rline", c1_rline, 0);
    $display("[TB] reset state sampled");
    bus.respcyc = 1'b0;
    #1 reset = 1'b1;
    tick();

    // Basic read, immediate ack.
    do_read(0, 64'h1047, 8'h10, 0, 1'b0);
    for (int i = 0; i < 8; i++) line_a[64*i +: 64] = 64'h10 + 64'(i);

    // Basic write, beat i = i.
    for (int i = 0; i < 8; i++) wl[64*i +: 64] = 64'(i);
    do_write(1, 64'h2000, wl);
    check("wr_no_rline", c1_rline, 0);

    // ADDR stall plus a foreign-tag response beat.
    do_read(1, 64'h3088, 8'h40, 5, 1'b1);
    check("c0_line_kept", c0_rline, line_a);

    // Simultaneous requests after reset, then alternating conflicts.
    reset_pulse();
    set_client(0, 1'b1, 1'b0, 64'h4000, '0);
    set_client(1, 1'b1, 1'b0, 64'h5000, '0);
    do_read(0, 64'h4000, 8'h50, 0, 1'b0);
    set_client(0, 1'b1, 1'b0, 64'h4100, '0);
    do_read(1, 64'h5000, 8'h60, 0, 1'b0);
    set_client(1, 1'b1, 1'b0, 64'h5100, '0);
    do_read(0, 64'h4100, 8'h58, 0, 1'b0);
    do_read(1, 64'h5100, 8'h68, 0, 1'b0);

    // Reset asserted during response beat 4.
    set_client(0, 1'b1, 1'b0, 64'h6000, '0);
    bus.reqack = 1'b1;
    tick();
    tick();
    bus.reqack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.respcyc = 1'b1;
      bus.resp    = 64'h70 + 64'(i);
      bus.resptag = 13'h1100;
      tick();
    end
    bus.resp = 64'h74;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_reqcyc", bus.reqcyc, 0);
    check("mid_rst_req", bus.req, 0);
    check("mid_rst_reqtag", bus.reqtag, 0);
    check("mid_rst_respack", bus.respack, 0);
    check("mid_rst_done", c0_done, 0);
    check("mid_rst_rline", c0_rline, 0);
    tick();
    check("mid_rst_done2", c0_done, 0);
    bus.respcyc = 1'b0;
    clear_req(0);
    #1 reset = 1'b1;
    tick();
    check("post_rst_done", c0_done, 0);
    $display("[TB] reset during read beat 4 aborted");
    do_read(0, 64'h7040, 8'h80, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
